// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the pipeline stage record.
// Used by the writeback/forwarding slice and its operand mux.
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic              wen;
        logic              is_load;
        logic [ADDR_W-1:0] wreg;
        logic [DATA_W-1:0] data;
    } stage_t;
endpackage

// File: rtl/fwd_select.sv
// Operand priority mux: r0, then MEM result, then WB write data, then register file.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the enables.
module fwd_select
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] rs,
    input  logic [DATA_W-1:0] rf_rdata,
    input  logic              mem_en,
    input  logic [ADDR_W-1:0] mem_wreg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_wreg,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] op
);
    always_comb begin
        op = rf_rdata;
        if (rs == REG_ZERO) begin
            op = '0;
        end else if (mem_en && (mem_wreg == rs)) begin
            op = mem_data;
        end else if (wb_en && (wb_wreg == rs)) begin
            // register file does not bypass, so a same-cycle write must be forwarded here
            op = wb_data;
        end
    end
endmodule

// File: rtl/regfile_writeback_fwd.sv
// MEM/WB pipeline registers driving the register-file write port, plus ID operand forwarding.
// Write reaches Wenable 2 edges after EX acceptance (longer while a load waits on memory).
// A load waiting on mem_ready holds MEM, drops ex_accept and raises stall; WB gets bubbles.
module regfile_writeback_fwd #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_wen,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_wreg,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              flush,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [DATA_W-1:0] id_op1,
    output logic [DATA_W-1:0] id_op2,
    output logic              stall,
    output logic              ex_accept,
    output logic [ADDR_W-1:0] Wreg,
    output logic [DATA_W-1:0] Wdata,
    output logic              Wenable,
    output logic [CNT_W-1:0]  wr_count
);
    import cpu_pkg::*;

    stage_t            mem_q;
    logic              wb_v;
    logic              wb_wen;
    logic [ADDR_W-1:0] wb_wreg;
    logic [DATA_W-1:0] wb_data;

    logic mem_done;
    logic mem_fwd_en;
    logic load_hazard;

    // A non-load leaves MEM every cycle; a load only once memory answers.
    assign mem_done  = mem_q.valid && (!mem_q.is_load || mem_ready);
    assign ex_accept = !mem_q.valid || mem_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '0;
        end else if (ex_accept) begin
            mem_q <= '{valid:   ex_valid && !flush,
                       wen:     ex_wen,
                       is_load: ex_is_load,
                       wreg:    ex_wreg,
                       data:    ex_result};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_v    <= 1'b0;
            wb_wen  <= 1'b0;
            wb_wreg <= '0;
            wb_data <= '0;
        end else begin
            wb_v <= mem_done;
            if (mem_done) begin
                wb_wen  <= mem_q.wen && (mem_q.wreg != REG_ZERO);
                wb_wreg <= mem_q.wreg;
                wb_data <= mem_q.is_load ? mem_rdata : mem_q.data;
            end
        end
    end

    assign Wenable = wb_v && wb_wen;
    assign Wreg    = wb_wreg;
    assign Wdata   = wb_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count <= '0;
        end else if (Wenable) begin
            wr_count <= wr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Load data is not known in MEM, so a dependent ID read must wait one cycle.
    assign mem_fwd_en  = mem_q.valid && mem_q.wen && !mem_q.is_load;
    assign load_hazard = mem_q.valid && mem_q.is_load && mem_q.wen &&
                         (mem_q.wreg != REG_ZERO) &&
                         ((mem_q.wreg == id_rs) || (mem_q.wreg == id_rt));
    assign stall       = load_hazard || !ex_accept;

    fwd_select u_fwd_rs (
        .rs       (id_rs),
        .rf_rdata (rf_rdata1),
        .mem_en   (mem_fwd_en),
        .mem_wreg (mem_q.wreg),
        .mem_data (mem_q.data),
        .wb_en    (Wenable),
        .wb_wreg  (wb_wreg),
        .wb_data  (wb_data),
        .op       (id_op1)
    );

    fwd_select u_fwd_rt (
        .rs       (id_rt),
        .rf_rdata (rf_rdata2),
        .mem_en   (mem_fwd_en),
        .mem_wreg (mem_q.wreg),
        .mem_data (mem_q.data),
        .wb_en    (Wenable),
        .wb_wreg  (wb_wreg),
        .wb_data  (wb_data),
        .op       (id_op2)
    );
endmodule

// File: tb/tb_regfile_writeback_fwd.sv
// Bench for regfile_writeback_fwd: directed scenarios then randomized traffic against an instruction-level model.
// The bench owns a non-bypassing register file fed by the DUT write port.
module tb_regfile_writeback_fwd;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_wen, ex_is_load, flush, mem_ready;
    logic [4:0]  ex_wreg, id_rs, id_rt, Wreg;
    logic [31:0] ex_result, mem_rdata, rf_rdata1, rf_rdata2, id_op1, id_op2, Wdata, wr_count;
    logic        stall, ex_accept, Wenable;

    logic [31:0] rf [32];
    int n_chk  = 0;
    int n_fail = 0;
    int exp_wr = 0;

    always #5 clk = ~clk;

    regfile_writeback_fwd dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .ex_wreg(ex_wreg), .ex_result(ex_result), .flush(flush),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .id_rs(id_rs), .id_rt(id_rt), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .id_op1(id_op1), .id_op2(id_op2), .stall(stall), .ex_accept(ex_accept),
        .Wreg(Wreg), .Wdata(Wdata), .Wenable(Wenable), .wr_count(wr_count)
    );

    always @(posedge clk) begin
        if (Wenable && (Wreg != 5'd0)) rf[Wreg] <= Wdata;
    end
    assign rf_rdata1 = rf[id_rs];
    assign rf_rdata2 = rf[id_rt];

    function automatic logic [31:0] ld_val(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_wen = 1'b0; ex_is_load = 1'b0; ex_wreg = 5'd0; ex_result = 32'd0;
    endtask

    task automatic drive_ex(input logic v, input logic w, input logic l, input logic [4:0] r, input logic [31:0] d);
        ex_valid = v; ex_wen = w; ex_is_load = l; ex_wreg = r; ex_result = d;
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if (Wenable !== 1'b0) begin n_fail++; $display("FAIL rst_wen got=%0h exp=0", Wenable); end
        n_chk++; if (Wreg !== 5'd0) begin n_fail++; $display("FAIL rst_wreg got=%0h exp=0", Wreg); end
        n_chk++; if (Wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wdata got=%0h exp=0", Wdata); end
        n_chk++; if (wr_count !== 32'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", wr_count); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%0h exp=0", stall); end
        n_chk++; if (ex_accept !== 1'b1) begin n_fail++; $display("FAIL rst_accept got=%0h exp=1", ex_accept); end
        rst = 1'b1;
        drive_ex(1, 1, 0, 5'd1, 32'hA);
        cyc();
        drive_ex(1, 1, 0, 5'd2, 32'hB);
        cyc();
        idle();
        cyc();
        n_chk++; if (wr_count !== 32'd1) begin n_fail++; $display("FAIL pre_rst_cnt got=%0d exp=1", wr_count); end
        n_chk++; if (Wenable !== 1'b1) begin n_fail++; $display("FAIL pre_rst_wen got=%0h exp=1", Wenable); end
        rst = 1'b0;
        #1;
        n_chk++; if (Wenable !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wen got=%0h exp=0", Wenable); end
        n_chk++; if (wr_count !== 32'd0) begin n_fail++; $display("FAIL mid_rst_cnt got=%0d exp=0", wr_count); end
        cyc();
        rst = 1'b1;
        drive_ex(1, 1, 0, 5'd4, 32'h44);
        #1;
        n_chk++; if (Wenable !== 1'b0) begin n_fail++; $display("FAIL post_rst_e0 got=%0h exp=0", Wenable); end
        cyc();
        idle();
        n_chk++; if (Wenable !== 1'b0) begin n_fail++; $display("FAIL post_rst_e1 got=%0h exp=0", Wenable); end
        cyc();
        n_chk++; if ({Wenable, Wreg, Wdata} !== {1'b1, 5'd4, 32'h44}) begin
            n_fail++; $display("FAIL post_rst_e2 got=%0h/%0d/%0h exp=1/4/44", Wenable, Wreg, Wdata); end
        cyc();
        exp_wr = 1;
        n_chk++; if (wr_count !== 32'(exp_wr)) begin n_fail++; $display("FAIL post_rst_cnt got=%0d exp=%0d", wr_count, exp_wr); end
        n_chk++; if (rf[2] !== 32'd0) begin n_fail++; $display("FAIL rst_killed_r2 got=%0h exp=0", rf[2]); end
    endtask

    task automatic test_alu_back_to_back();
        drive_ex(1, 1, 0, 5'd5, 32'h11);
        cyc();
        idle(); id_rs = 5'd5;
        #1;
        n_chk++; if (id_op1 !== 32'h11) begin n_fail++; $display("FAIL b2b_mem got=%0h exp=11", id_op1); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got=%0h exp=0", stall); end
        cyc();
        n_chk++; if (id_op1 !== 32'h11) begin n_fail++; $display("FAIL b2b_wb got=%0h exp=11", id_op1); end
        n_chk++; if (rf_rdata1 !== 32'h0) begin n_fail++; $display("FAIL b2b_stale got=%0h exp=0", rf_rdata1); end
        n_chk++; if (Wenable !== 1'b1) begin n_fail++; $display("FAIL b2b_wen got=%0h exp=1", Wenable); end
        cyc();
        n_chk++; if (id_op1 !== 32'h11) begin n_fail++; $display("FAIL b2b_rf got=%0h exp=11", id_op1); end
        id_rs = 5'd0;
        drive_ex(1, 1, 0, 5'd6, 32'h1);
        cyc();
        drive_ex(1, 1, 0, 5'd6, 32'h2);
        cyc();
        idle(); id_rs = 5'd6;
        #1;
        n_chk++; if (id_op1 !== 32'h2) begin n_fail++; $display("FAIL mem_over_wb got=%0h exp=2", id_op1); end
        n_chk++; if ({Wenable, Wreg, Wdata} !== {1'b1, 5'd6, 32'h1}) begin
            n_fail++; $display("FAIL mem_over_wb_port got=%0h/%0d/%0h exp=1/6/1", Wenable, Wreg, Wdata); end
        cyc();
        n_chk++; if (id_op1 !== 32'h2) begin n_fail++; $display("FAIL wb_second got=%0h exp=2", id_op1); end
        cyc();
        id_rs = 5'd0;
        exp_wr += 3;
        n_chk++; if (wr_count !== 32'(exp_wr)) begin n_fail++; $display("FAIL b2b_cnt got=%0d exp=%0d", wr_count, exp_wr); end
    endtask

    task automatic test_load_use();
        drive_ex(1, 1, 1, 5'd7, 32'h100);
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        cyc();
        idle(); id_rt = 5'd7;
        #1;
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%0h exp=1", stall); end
        n_chk++; if (ex_accept !== 1'b1) begin n_fail++; $display("FAIL lu_accept got=%0h exp=1", ex_accept); end
        cyc();
        mem_rdata = 32'h0;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_unstall got=%0h exp=0", stall); end
        n_chk++; if (id_op2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lu_op2 got=%0h exp=deadbeef", id_op2); end
        n_chk++; if ({Wenable, Wreg, Wdata} !== {1'b1, 5'd7, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL lu_port got=%0h/%0d/%0h exp=1/7/deadbeef", Wenable, Wreg, Wdata); end
        cyc();
        id_rt = 5'd0;
        exp_wr += 1;
    endtask

    task automatic test_mem_wait();
        drive_ex(1, 1, 1, 5'd9, 32'h200);
        mem_ready = 1'b0;
        cyc();
        drive_ex(1, 1, 0, 5'd10, 32'h55);
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (ex_accept !== 1'b0) begin n_fail++; $display("FAIL wait_accept[%0d] got=%0h exp=0", i, ex_accept); end
            n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wait_stall[%0d] got=%0h exp=1", i, stall); end
            n_chk++; if (Wenable !== 1'b0) begin n_fail++; $display("FAIL wait_wen[%0d] got=%0h exp=0", i, Wenable); end
            cyc();
        end
        flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
        #1;
        n_chk++; if (ex_accept !== 1'b1) begin n_fail++; $display("FAIL wait_done_accept got=%0h exp=1", ex_accept); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wait_done_stall got=%0h exp=0", stall); end
        cyc();
        idle(); mem_rdata = 32'h0;
        n_chk++; if ({Wenable, Wreg, Wdata} !== {1'b1, 5'd9, 32'hCAFE0001}) begin
            n_fail++; $display("FAIL wait_load_wr got=%0h/%0d/%0h exp=1/9/cafe0001", Wenable, Wreg, Wdata); end
        cyc();
        n_chk++; if ({Wenable, Wreg, Wdata} !== {1'b1, 5'd10, 32'h55}) begin
            n_fail++; $display("FAIL wait_alu_wr got=%0h/%0d/%0h exp=1/10/55", Wenable, Wreg, Wdata); end
        cyc();
        n_chk++; if (Wenable !== 1'b0) begin n_fail++; $display("FAIL wait_tail got=%0h exp=0", Wenable); end
        exp_wr += 2;
    endtask

    task automatic test_r0();
        drive_ex(1, 1, 0, 5'd0, 32'hFFFF);
        cyc();
        idle(); id_rs = 5'd0;
        #1;
        n_chk++; if (id_op1 !== 32'h0) begin n_fail++; $display("FAIL r0_op1 got=%0h exp=0", id_op1); end
        cyc();
        n_chk++; if (Wenable !== 1'b0) begin n_fail++; $display("FAIL r0_wen got=%0h exp=0", Wenable); end
        cyc();
        n_chk++; if (wr_count !== 32'(exp_wr)) begin n_fail++; $display("FAIL r0_cnt got=%0d exp=%0d", wr_count, exp_wr); end
    endtask

    task automatic test_flush();
        drive_ex(1, 1, 0, 5'd3, 32'h33);
        flush = 1'b1;
        cyc();
        flush = 1'b0; idle(); id_rs = 5'd3;
        #1;
        n_chk++; if (id_op1 !== 32'h0) begin n_fail++; $display("FAIL flush_fwd got=%0h exp=0", id_op1); end
        cyc();
        n_chk++; if (Wenable !== 1'b0) begin n_fail++; $display("FAIL flush_wen got=%0h exp=0", Wenable); end
        n_chk++; if (id_op1 !== 32'h0) begin n_fail++; $display("FAIL flush_fwd_wb got=%0h exp=0", id_op1); end
        cyc();
        id_rs = 5'd0;
        n_chk++; if (rf[3] !== 32'h0) begin n_fail++; $display("FAIL flush_r3 got=%0h exp=0", rf[3]); end
        n_chk++; if (wr_count !== 32'(exp_wr)) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=%0d", wr_count, exp_wr); end
    endtask

    // Model tracks the newest architectural value of each register and the
    // instruction most recently taken from EX; writes land one cycle after it completes.
    task automatic test_random();
        logic [31:0] newest [32];
        logic        m_v, m_wen, m_load, w_en, busy, hz, exp_acc, exp_stall, done;
        logic [4:0]  m_wreg, w_reg;
        logic [31:0] m_res, w_data, e1, e2;
        for (int r = 0; r < 32; r++) newest[r] = 32'd0;
        m_v = 0; m_wen = 0; m_load = 0; m_wreg = 0; m_res = 0;
        w_en = 0; w_reg = 0; w_data = 0;
        for (int it = 0; it < 400; it++) begin
            if (it < 7) begin
                drive_ex(1, 1, 0, 5'(it + 1), $urandom);
                flush = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
            end else begin
                drive_ex(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
                         ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom);
                flush = ($urandom_range(0, 7) == 0);
                id_rs = 5'($urandom_range(0, 7));
                id_rt = 5'($urandom_range(0, 7));
            end
            mem_ready = ($urandom_range(0, 2) != 0);
            mem_rdata = ld_val(m_res);
            #1;
            busy      = m_v && m_load && !mem_ready;
            exp_acc   = !busy;
            hz        = m_v && m_load && m_wen && (m_wreg != 0) && ((m_wreg == id_rs) || (m_wreg == id_rt));
            exp_stall = busy || hz;
            n_chk++; if (ex_accept !== exp_acc) begin n_fail++; $display("FAIL rnd_accept it=%0d got=%0h exp=%0h", it, ex_accept, exp_acc); end
            n_chk++; if (stall !== exp_stall) begin n_fail++; $display("FAIL rnd_stall it=%0d got=%0h exp=%0h", it, stall, exp_stall); end
            n_chk++; if (Wenable !== w_en) begin n_fail++; $display("FAIL rnd_wen it=%0d got=%0h exp=%0h", it, Wenable, w_en); end
            if (w_en) begin
                n_chk++; if ({Wreg, Wdata} !== {w_reg, w_data}) begin
                    n_fail++; $display("FAIL rnd_wport it=%0d got=%0d/%0h exp=%0d/%0h", it, Wreg, Wdata, w_reg, w_data); end
            end
            n_chk++; if (wr_count !== 32'(exp_wr)) begin n_fail++; $display("FAIL rnd_cnt it=%0d got=%0d exp=%0d", it, wr_count, exp_wr); end
            if (!exp_stall) begin
                e1 = (id_rs == 0) ? 32'd0 : newest[id_rs];
                e2 = (id_rt == 0) ? 32'd0 : newest[id_rt];
                n_chk++; if (id_op1 !== e1) begin n_fail++; $display("FAIL rnd_op1 it=%0d rs=%0d got=%0h exp=%0h", it, id_rs, id_op1, e1); end
                n_chk++; if (id_op2 !== e2) begin n_fail++; $display("FAIL rnd_op2 it=%0d rt=%0d got=%0h exp=%0h", it, id_rt, id_op2, e2); end
            end
            @(posedge clk);
            if (w_en) exp_wr++;
            done   = m_v && (!m_load || mem_ready);
            w_en   = done && m_wen && (m_wreg != 0);
            w_reg  = m_wreg;
            w_data = m_load ? ld_val(m_res) : m_res;
            if (exp_acc) begin
                m_v = ex_valid && !flush; m_wen = ex_wen; m_load = ex_is_load; m_wreg = ex_wreg; m_res = ex_result;
                if (m_v && ex_wen && (ex_wreg != 0))
                    newest[ex_wreg] = ex_is_load ? ld_val(ex_result) : ex_result;
            end
            #1;
        end
        idle(); flush = 1'b0; mem_ready = 1'b1; mem_rdata = ld_val(m_res);
        id_rs = 5'd0; id_rt = 5'd0;
        if (w_en) exp_wr++;
        if (m_v && m_wen && (m_wreg != 0)) exp_wr++;
        for (int i = 0; i < 4; i++) cyc();
        n_chk++; if (wr_count !== 32'(exp_wr)) begin n_fail++; $display("FAIL rnd_drain_cnt got=%0d exp=%0d", wr_count, exp_wr); end
        for (int r = 1; r < 8; r++) begin
            n_chk++; if (rf[r] !== newest[r]) begin n_fail++; $display("FAIL rnd_rf r%0d got=%0h exp=%0h", r, rf[r], newest[r]); end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = 32'd0;
        rst = 1'b0;
        idle();
        flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'd0;
        id_rs = 5'd0; id_rt = 5'd0;
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_mem_wait();
        test_r0();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
